register_multi_mode: RTL and testbench

Parametrised multi-function register: the next generation of the plain multi-bit D flip-flop. Adds clock enable, synchronous reload of the reset value, shift/rotate with serial in/out, and single-bit set/clear. Used for the emulator's I/O and status registers, such as SREG bit ops, port latches and shift-based peripherals, where one register must support several update modes.

---
 rtl/register_multi_mode.sv | 122 ++++++++++++
 tb/tb_register_multi_mode.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/register_multi_mode.sv
// -----------------------------------------------------------------------------
// register_multi_mode
//
// Multi-function register for emulator I/O and status registers (status-bit
// ops, port latches, shift-based peripherals). One register, several update
// modes, selected per cycle and gated by a clock enable.
//
// Parameters
//   WIDTH     register width in bits (2..32)
//   RESETVAL  value loaded by async reset and by CLR; truncated to WIDTH bits
//   SELW      width of bit_sel, derived from WIDTH
//
// Ports
//   clk         system clock, rising edge
//   clr_n       asynchronous active-low reset, loads RESETVAL
//   en          clock enable; 0 holds Q and serial_out
//   mode        HOLD/LOAD/CLR/SHL/SHR/ROL/SETB/CLRB
//   d           parallel load data
//   bit_sel     bit index for SETB/CLRB
//   serial_in   bit entering the vacated position on SHL/SHR
//   Q, Qn       registered value and its bitwise inverse
//   serial_out  registered copy of the bit shifted/rotated out last
//   zero        1 when Q == 0
//   changed     one-cycle pulse: the last edge altered Q
// -----------------------------------------------------------------------------
module register_multi_mode #(
    parameter int unsigned  WIDTH    = 8,
    parameter logic [31:0]  RESETVAL = 32'd0,
    localparam int unsigned SELW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [SELW-1:0]  bit_sel,
    input  logic             serial_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             serial_out,
    output logic             zero,
    output logic             changed
);

    localparam logic [WIDTH-1:0] RST_Q = RESETVAL[WIDTH-1:0];

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_CLR  = 3'b010,
        MODE_SHL  = 3'b011,
        MODE_SHR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_SETB = 3'b110,
        MODE_CLRB = 3'b111
    } mode_e;

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] bit_mask;
    logic             so_q, so_d;
    logic             changed_q, changed_d;

    assign mode_s = mode_e'(mode);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        q_d      = q_q;
        so_d     = so_q;
        // An index past the top bit shifts the one out entirely, leaving an
        // all-zero mask: SETB/CLRB then degrade to HOLD with no extra compare.
        bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_sel;

        if (en) begin
            case (mode_s)
                MODE_HOLD: ;
                MODE_LOAD: q_d = d;
                MODE_CLR:  q_d = RST_Q;
                MODE_SHL: begin
                    q_d  = {q_q[WIDTH-2:0], serial_in};
                    so_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d  = {serial_in, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                MODE_ROL: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                MODE_SETB: q_d = q_q | bit_mask;
                MODE_CLRB: q_d = q_q & ~bit_mask;
                default: ;
            endcase
        end

        // Held edges naturally yield 0 here.
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q       <= RST_Q;
            so_q      <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register sample the
            // pre-edge values, independent of statement order.
            q_q       <= q_d;
            so_q      <= so_d;
            changed_q <= changed_d;
        end
    end

    assign Q          = q_q;
    assign Qn         = ~q_q;
    assign zero       = (q_q == '0);
    assign serial_out = so_q;
    assign changed    = changed_q;

endmodule

// File: tb/tb_register_multi_mode.sv
// -----------------------------------------------------------------------------
// Bench for register_multi_mode: an 8-bit instance (RESETVAL=A5) and a 5-bit
// instance (RESETVAL=0A) run side by side on shared control inputs. A
// behavioural model computes expected state with plain integer arithmetic; a
// compare process checks every output of both instances on each falling edge,
// and directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_register_multi_mode;

    localparam int HOLD = 0, LOAD = 1, CLR = 2, SHL = 3, SHR = 4, ROL = 5, SETB = 6, CLRB = 7;
    localparam int RV8 = 'hA5;
    localparam int RV5 = 'h0A;

    logic       clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d8 = 8'd0;
    logic [4:0] d5 = 5'd0;
    logic [2:0] sel8 = 3'd0;
    logic [2:0] sel5 = 3'd0;
    logic       si = 1'b0;

    logic [7:0] q8, qn8;
    logic [4:0] q5, qn5;
    logic       so8, z8, ch8, so5, z5, ch5;

    always #5 clk = ~clk;

    register_multi_mode #(.WIDTH(8), .RESETVAL(32'hA5)) dut8 (
        .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .d(d8), .bit_sel(sel8),
        .serial_in(si), .Q(q8), .Qn(qn8), .serial_out(so8), .zero(z8), .changed(ch8)
    );

    register_multi_mode #(.WIDTH(5), .RESETVAL(32'h0A)) dut5 (
        .clk(clk), .clr_n(clr_n), .en(en), .mode(mode), .d(d5), .bit_sel(sel5),
        .serial_in(si), .Q(q5), .Qn(qn5), .serial_out(so5), .zero(z5), .changed(ch5)
    );

    int n_pass   = 0;
    int n_checks = 0;
    bit cmp_on   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---- behavioural model: integer arithmetic on the register value ----
    function automatic int model_q(int w, int rv, int q, int m, int dd, int sel, int s);
        int mask = (1 << w) - 1;
        case (m)
            LOAD:    return dd & mask;
            CLR:     return rv;
            SHL:     return ((q << 1) | s) & mask;
            SHR:     return (q >> 1) | (s << (w - 1));
            ROL:     return ((q << 1) | (q >> (w - 1))) & mask;
            SETB:    return (sel < w) ? (q | (1 << sel)) : q;
            CLRB:    return (sel < w) ? (q & ~(1 << sel) & mask) : q;
            default: return q;
        endcase
    endfunction

    function automatic int model_so(int w, int q, int m, int so);
        if (m == SHL || m == ROL) return (q >> (w - 1)) & 1;
        if (m == SHR)             return q & 1;
        return so;
    endfunction

    int m8_q = RV8, m8_so = 0, m8_ch = 0;
    int m5_q = RV5, m5_so = 0, m5_ch = 0;

    always @(posedge clk or negedge clr_n) begin : model
        int n8, n5;
        if (!clr_n) begin
            m8_q <= RV8; m8_so <= 0; m8_ch <= 0;
            m5_q <= RV5; m5_so <= 0; m5_ch <= 0;
        end else begin
            n8 = en ? model_q(8, RV8, m8_q, int'(mode), int'(d8), int'(sel8), int'(si)) : m8_q;
            n5 = en ? model_q(5, RV5, m5_q, int'(mode), int'(d5), int'(sel5), int'(si)) : m5_q;
            m8_so <= en ? model_so(8, m8_q, int'(mode), m8_so) : m8_so;
            m5_so <= en ? model_so(5, m5_q, int'(mode), m5_so) : m5_so;
            m8_ch <= int'(n8 != m8_q);
            m5_ch <= int'(n5 != m5_q);
            m8_q  <= n8;
            m5_q  <= n5;
        end
    end

    // ---- compare process: every output, every falling edge ----
    always @(negedge clk) begin
        if (cmp_on) begin
            check("q8",   int'(q8),   m8_q);
            check("qn8",  int'(qn8),  (~m8_q) & 'hFF);
            check("so8",  int'(so8),  m8_so);
            check("z8",   int'(z8),   int'(m8_q == 0));
            check("ch8",  int'(ch8),  m8_ch);
            check("q5",   int'(q5),   m5_q);
            check("qn5",  int'(qn5),  (~m5_q) & 'h1F);
            check("so5",  int'(so5),  m5_so);
            check("z5",   int'(z5),   int'(m5_q == 0));
            check("ch5",  int'(ch5),  m5_ch);
        end
    end

    // Drive one operation at the falling edge, then return 1 time unit after
    // the rising edge that executes it.
    task automatic drive(input logic e, input int m, input logic [7:0] a8, input logic [4:0] a5,
                         input logic [2:0] s8, input logic [2:0] s5, input logic s);
        @(negedge clk);
        en = e; mode = 3'(m); d8 = a8; d5 = a5; sel8 = s8; sel5 = s5; si = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Async reset asserted mid-cycle: outputs respond without a clock edge.
        #3 clr_n = 1'b0;
        #1;
        check("rst_q8",  int'(q8),  'hA5);
        check("rst_qn8", int'(qn8), 'h5A);
        check("rst_so8", int'(so8), 0);
        check("rst_ch8", int'(ch8), 0);
        check("rst_z8",  int'(z8),  0);
        check("rst_q5",  int'(q5),  'h0A);
        check("rst_qn5", int'(qn5), 'h15);
        cmp_on = 1'b1;

        // Release with HOLD: first edge executes HOLD, value unchanged.
        @(negedge clk);
        clr_n = 1'b1; en = 1'b1; mode = 3'(HOLD);
        @(posedge clk); #1;
        check("rel_q8",  int'(q8),  'hA5);
        check("rel_ch8", int'(ch8), 0);

        // Load / enable / synchronous reload.
        drive(1, LOAD, 8'h3C, 5'h13, 0, 0, 0);
        check("load_q8",  int'(q8),  'h3C);
        check("load_ch8", int'(ch8), 1);
        drive(0, LOAD, 8'hFF, 5'h1F, 0, 0, 0);
        check("en0_q8",  int'(q8),  'h3C);
        check("en0_ch8", int'(ch8), 0);
        drive(1, CLR, 8'h00, 5'h00, 0, 0, 0);
        check("clr_q8", int'(q8), 'hA5);

        // Shifts and rotate.
        drive(1, LOAD, 8'h81, 5'h11, 0, 0, 0);
        drive(1, SHL, 8'h00, 5'h00, 0, 0, 0);
        check("shl_q8",  int'(q8),  'h02);
        check("shl_so8", int'(so8), 1);
        drive(1, SHR, 8'h00, 5'h00, 0, 0, 1);
        check("shr_q8",  int'(q8),  'h81);
        check("shr_so8", int'(so8), 0);
        drive(1, ROL, 8'h00, 5'h00, 0, 0, 0);
        check("rol_q8",  int'(q8),  'h03);
        check("rol_so8", int'(so8), 1);

        // Bit operations.
        drive(1, LOAD, 8'h00, 5'h10, 0, 0, 0);
        check("ld0_z8", int'(z8), 1);
        drive(1, SETB, 8'h00, 5'h00, 3'd7, 3'd0, 0);
        check("setb_q8", int'(q8), 'h80);
        check("setb_z8", int'(z8), 0);
        drive(1, SETB, 8'h00, 5'h00, 3'd7, 3'd0, 0);
        check("setb2_q8",  int'(q8),  'h80);
        check("setb2_ch8", int'(ch8), 0);
        drive(1, CLRB, 8'h00, 5'h00, 3'd7, 3'd0, 0);
        check("clrb_q8", int'(q8), 'h00);
        check("clrb_z8", int'(z8), 1);

        // Odd width: out-of-range bit index is a no-op; SHL drops the MSB.
        drive(1, LOAD, 8'h55, 5'h10, 0, 0, 0);
        check("ld_q5", int'(q5), 'h10);
        drive(1, SETB, 8'h00, 5'h00, 3'd0, 3'd6, 0);
        check("oor_q5",  int'(q5),  'h10);
        check("oor_ch5", int'(ch5), 0);
        drive(1, SHL, 8'h00, 5'h00, 0, 0, 0);
        check("shl5_q5",  int'(q5),  'h00);
        check("shl5_so5", int'(so5), 1);
        check("shl5_z5",  int'(z5),  1);

        // Reset in the middle of a shift burst.
        drive(1, LOAD, 8'h81, 5'h11, 0, 0, 0);
        drive(1, SHL, 8'h00, 5'h00, 0, 0, 1);
        check("b1_q8", int'(q8), 'h03);
        drive(1, SHL, 8'h00, 5'h00, 0, 0, 1);
        check("b2_q8", int'(q8), 'h07);
        #2 clr_n = 1'b0;
        #1;
        check("brst_q8",  int'(q8),  'hA5);
        check("brst_so8", int'(so8), 0);
        check("brst_ch8", int'(ch8), 0);
        check("brst_q5",  int'(q5),  'h0A);
        @(posedge clk); #1;
        check("bhold_q8", int'(q8), 'hA5);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk); #1;
        check("b3_q8",  int'(q8),  'h4B);
        check("b3_so8", int'(so8), 1);
        check("b3_q5",  int'(q5),  'h15);
        drive(1, SHL, 8'h00, 5'h00, 0, 0, 1);
        check("b4_q8",  int'(q8),  'h97);
        check("b4_so8", int'(so8), 0);

        @(negedge clk);
        cmp_on = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
